// File: rtl/display_scan_pkg.sv
// Shared types and helpers for the display scan controller.
// Optional PWM brightness: DISPLAY_SCAN_BRIGHTNESS_EN.
package display_scan_pkg;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_BLANK,
    ST_SHOW
  } state_t;

  localparam int NUM_DIGITS = 4;

  // Search order starts at cur (inclusive) or cur+1, wrapping mod 4.
  function automatic logic [1:0] next_digit(
    input logic [3:0] mask,
    input logic [1:0] cur,
    input logic       inclusive
  );
    logic [1:0] idx;
    logic       found;
    next_digit = cur;
    found = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      idx = cur + 2'(i) + (inclusive ? 2'd0 : 2'd1);
      if (!found && mask[idx]) begin
        next_digit = idx;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] onehot_n(
    input logic [1:0] sel
  );
    onehot_n = ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_prescaler.sv
// SHOW-phase timer: counts 0..DIV-1 while enabled.
// Optional PWM brightness: DISPLAY_SCAN_BRIGHTNESS_EN.
module scan_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tc) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit 7-segment scan controller with blanking gaps.
// Optional PWM brightness: DISPLAY_SCAN_BRIGHTNESS_EN.
module display_scan_ctrl
  import display_scan_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ENABLE,
  input  logic [3:0] DIGIT_MASK,
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
  input  logic [3:0] BRIGHT,
`endif
  output logic [1:0] SEL,
  output logic [3:0] AN,
  output logic       BLANK,
  output logic       FRAME_TICK
);

  localparam logic [7:0] BLAST = 8'(BLANK_CYC - 1);

  state_t     state, state_n;
  logic [1:0] sel_n;
  logic       tick_n;
  logic       lit_n;
  logic [7:0] bcnt, bcnt_n;
  logic       pre_clr;
  logic       pre_tc;
  logic       in_show;

  assign in_show = (state == ST_SHOW);
  assign pre_clr = (state_n != ST_SHOW);

  scan_prescaler #(
    .DIV(DIV)
  ) u_pre (
    .clk  (CLK),
    .rst_n(RST_N),
    .clr  (pre_clr),
    .en   (in_show),
    .tc   (pre_tc)
  );

  // Priority: enable, empty mask, digit abort, timer expiry.
  always_comb begin
    state_n = state;
    sel_n   = SEL;
    tick_n  = 1'b0;
    if (!ENABLE) begin
      state_n = ST_OFF;
    end else if (state == ST_OFF) begin
      if (DIGIT_MASK != 4'h0) begin
        state_n = ST_BLANK;
        sel_n   = next_digit(DIGIT_MASK, 2'd0, 1'b1);
      end
    end else if (DIGIT_MASK == 4'h0) begin
      state_n = ST_OFF;
    end else if (in_show &&
                 (!DIGIT_MASK[SEL] || pre_tc)) begin
      state_n = ST_BLANK;
      sel_n   = next_digit(DIGIT_MASK, SEL, 1'b0);
      tick_n  = (sel_n <= SEL);
    end else if (state == ST_BLANK && bcnt == BLAST) begin
      state_n = ST_SHOW;
    end
  end

  always_comb begin
    bcnt_n = 8'd0;
    if (state == ST_BLANK && state_n == ST_BLANK) begin
      bcnt_n = bcnt + 8'd1;
    end
  end

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
  logic [3:0] pwm, pwm_n;

  assign pwm_n = pwm + 4'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pwm <= 4'd0;
    end else begin
      pwm <= pwm_n;
    end
  end

  assign lit_n = (state_n == ST_SHOW) && (pwm_n <= BRIGHT);
`else
  assign lit_n = (state_n == ST_SHOW);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_OFF;
      SEL        <= 2'd0;
      AN         <= 4'hF;
      BLANK      <= 1'b1;
      FRAME_TICK <= 1'b0;
      bcnt       <= 8'd0;
    end else begin
      state      <= state_n;
      SEL        <= sel_n;
      AN         <= lit_n ? onehot_n(sel_n) : 4'hF;
      BLANK      <= !lit_n;
      FRAME_TICK <= tick_n;
      bcnt       <= bcnt_n;
    end
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Scan controller for the four-digit multiplexed 7-segment display. It drives the 2-bit SEL of the 4:1 x4 nibble mux and the matching active-low digit anodes. It inserts a blanking gap at every digit change to prevent ghosting, skips masked digits, and flags frame wrap. It sits between the nibble sources/mux and the seven-segment decoder/anode pins.

Parameters:
DIV, 50000, SHOW duration per digit in CLK cycles (1 kHz/digit at 50 MHz); range 2..2^20
BLANK_CYC, 8, BLANK duration in CLK cycles between digits; range 1..255

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
ENABLE  input  1  scan enable; 0 forces display dark
DIGIT_MASK  input  4  bit i = 1 means digit i is scanned
SEL  output  2  mux select / current digit index
AN  output  4  active-low one-hot anode drive
BLANK  output  1  1 when no anode is active
FRAME_TICK  output  1  one-cycle pulse when scan wraps to a lower-or-equal index

Behaviour:
- One clock CLK; reset is asynchronous, active-low on RST_N. All state is registered; AN, SEL, BLANK and FRAME_TICK are register outputs.
- Reset values: state OFF, SEL=0, AN=4'hF, BLANK=1, FRAME_TICK=0, all counters 0. Reset mid-scan returns to these values immediately.
- FSM states are OFF, BLANK and SHOW.
- OFF:
  - AN=F, BLANK=1, SEL held.
  - If ENABLE=1 and DIGIT_MASK!=0, go to BLANK next cycle with SEL = lowest set mask bit (search from index 0 inclusive). No FRAME_TICK is issued.
- BLANK:
  - AN=F, BLANK=1; blank counter runs 0..BLANK_CYC-1.
  - On the last count, go to SHOW. The prescaler is cleared on entry to SHOW.
- SHOW:
  - AN = ~(1<<SEL), BLANK=0. The prescaler counts 0..DIV-1, so SHOW lasts exactly DIV cycles.
  - On the terminal count, compute next = first set mask bit searching SEL+1, SEL+2, ... with mod-4 wrap, ending at SEL itself. Load SEL=next and go to BLANK.
  - If next <= old SEL, pulse FRAME_TICK in that same cycle. A single enabled digit therefore pulses FRAME_TICK every DIV+BLANK_CYC cycles and still blanks between refreshes.
- Period per enabled digit is BLANK_CYC+DIV cycles; with N enabled digits the frame is N*(BLANK_CYC+DIV).
- ENABLE=0 in any state: go to OFF next cycle. AN=F on that edge, counters cleared, SEL held.
- DIGIT_MASK change:
  - Sampled continuously.
  - If the current SEL bit clears during SHOW, abort to BLANK next cycle with next enabled digit (same search and FRAME_TICK rule).
  - If the mask becomes 0 in BLANK or SHOW, go to OFF.
  - Newly set bits take effect at the next search.
- Simultaneous events: ENABLE=0 has priority over mask abort, which has priority over prescaler terminal count.
- Counter widths: $clog2(DIV) and 8 bits. No overflow is possible within the legal parameter ranges.

Optional Feature:
- Macro: DISPLAY_SCAN_BRIGHTNESS_EN.
- With the macro:
  - Adds input BRIGHT[3:0] and a free-running 4-bit PWM counter (reset 0, counts every CLK).
  - In SHOW, the anode is asserted only while pwm_cnt <= BRIGHT, giving a duty of (BRIGHT+1)/16. BLANK follows the actual anode state.
  - BRIGHT=15 behaves identically to the build without the macro.
- Without the macro: no BRIGHT port, no PWM counter, full duty in SHOW.

Decomposition:
- Package display_scan_pkg:
  - state encoding for OFF/BLANK/SHOW
  - digit count constant 4
  - function next_digit(mask, cur, inclusive) returning the 2-bit index
  - function onehot_n(sel) returning active-low AN
- Sub-module scan_prescaler: clear/enable/terminal-count counter with parameter DIV, instantiated for the SHOW timer. The blank counter is inline.

Test Plan:
All scenarios use DIV=4, BLANK_CYC=2.
- Reset release, ENABLE=1, MASK=F: 1 cycle OFF, then SEL=0 with 2 cycles AN=F. Then AN=E for 4 cycles, 2 cycles blank, then SEL=1 with AN=D. FRAME_TICK fires on the 3->0 transition; period 24 cycles.
- MASK=4'b1010: SEL sequence 1,3,1,3 with AN=D/7. FRAME_TICK on each 3->1 transition; frame 12 cycles. Digits 0 and 2 are never driven.
- MASK=4'b0100: SEL stays 2; AN alternates F for 2 cycles, B for 4 cycles. FRAME_TICK every 6 cycles.
- During SHOW of digit 1 with MASK=F, clear bit 1: next cycle AN=F, SEL=2, BLANK=1. MASK=0 then gives OFF with AN=F held.
- ENABLE drops mid-SHOW: AN=F on the next edge and SEL is held. Re-enable: restarts from the lowest enabled digit with a full BLANK phase. RST_N asserted asynchronously mid-BLANK forces AN=F and SEL=0 without waiting for a clock.
- Macro build, BRIGHT=3, DIV=32: in SHOW, AN is active 4 of every 16 cycles. BRIGHT=15 matches the non-macro waveform cycle for cycle.
